// File: rtl/rect_program_sequencer_if.sv
// Command port of rect_program_sequencer: valid/ready rectangle descriptor
// handshake plus the one-cycle reject pulse.
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  FIFO not full
//   cmd_index  master->slave  target renderer stage
//   cmd_x/y/w/h/color         values for reg IDs 0..4
//   cmd_mask   master->slave  bit i set = write reg ID i
//   cmd_err    slave->master  command rejected (index out of range)
interface rect_program_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_index;
  logic [11:0] cmd_x;
  logic [11:0] cmd_y;
  logic [11:0] cmd_w;
  logic [11:0] cmd_h;
  logic [11:0] cmd_color;
  logic [4:0]  cmd_mask;
  logic        cmd_err;

  modport master (
    output cmd_valid, cmd_index, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mask,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mask,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/rect_program_sequencer.sv
// Head-of-chain controller for the rect_renderer pipeline. Buffers rectangle
// descriptors in a FIFO and serialises each into programming words that are
// inserted into the pixel stream only during blanking slots.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd (slave)                     command handshake, see interface
//   px_x_in, px_y_in, px_data_in    incoming pixel stream
//   px_active, vblank               visible-pixel qualifier, vertical blank
//   program_out, x_out, y_out,
//   data_out                        registered stream to first renderer
//   busy                            FIFO non-empty or FSM active
//   fifo_count                      entries held in the FIFO
module rect_program_sequencer #(
  parameter int unsigned NUM_SHAPES  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned VBLANK_ONLY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rect_program_sequencer_if.slave       cmd,
  input  logic [11:0]                   px_x_in,
  input  logic [11:0]                   px_y_in,
  input  logic [11:0]                   px_data_in,
  input  logic                          px_active,
  input  logic                          vblank,
  output logic                          program_out,
  output logic [11:0]                   x_out,
  output logic [11:0]                   y_out,
  output logic [11:0]                   data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned DW      = 12;
  localparam int unsigned NREG    = 5;
  localparam int unsigned VALS_W  = DW * NREG;
  localparam int unsigned ENTRY_W = DW + VALS_W + NREG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // FIFO entry layout: {mask, color, h, w, y, x, index}
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head_c;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0]   count_d;

  state_t             state, state_d;
  logic [DW-1:0]      wk_index, wk_index_d;
  logic [VALS_W-1:0]  wk_vals, wk_vals_d;
  logic [NREG-1:0]    rem_mask, rem_mask_d;
  logic [NREG-1:0]    rem_next;
  logic [2:0]         cur_id, cur_id_d;

  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               program_d;
  logic [DW-1:0]      x_d, y_d, data_d;
  logic               busy_d;

  logic               slot_c;
  logic               idx_ok_c;
  logic               hs_c;
  logic               push_c;
  logic               pop_c;

  // Lowest set bit of a register mask, i.e. next register ID to emit.
  function automatic logic [2:0] first_id(input logic [NREG-1:0] m);
    first_id = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (m[i]) first_id = 3'(i);
    end
  endfunction

  // Value for a register ID from the packed working values.
  function automatic logic [DW-1:0] sel_val(input logic [VALS_W-1:0] v, input logic [2:0] id);
    case (id)
      3'd0:    sel_val = v[0*DW +: DW];
      3'd1:    sel_val = v[1*DW +: DW];
      3'd2:    sel_val = v[2*DW +: DW];
      3'd3:    sel_val = v[3*DW +: DW];
      3'd4:    sel_val = v[4*DW +: DW];
      default: sel_val = '0;
    endcase
  endfunction

  assign cmd.cmd_ready = ready_q;
  assign cmd.cmd_err   = err_q;

  // Programming words may only replace non-visible pixels.
  assign slot_c   = ~px_active & ((VBLANK_ONLY != 0) ? vblank : 1'b1);
  assign idx_ok_c = 32'(cmd.cmd_index) < NUM_SHAPES;
  assign hs_c     = cmd.cmd_valid & ready_q;
  assign push_c   = hs_c & idx_ok_c;
  assign pop_c    = (state == IDLE) && (fifo_count != '0);
  assign head_c   = mem[rd_ptr];

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {cmd.cmd_mask, cmd.cmd_color, cmd.cmd_h, cmd.cmd_w,
                      cmd.cmd_y, cmd.cmd_x, cmd.cmd_index};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      wk_index    <= '0;
      wk_vals     <= '0;
      rem_mask    <= '0;
      cur_id      <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      fifo_count  <= count_d;
      wk_index    <= wk_index_d;
      wk_vals     <= wk_vals_d;
      rem_mask    <= rem_mask_d;
      cur_id      <= cur_id_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      program_out <= program_d;
      x_out       <= x_d;
      y_out       <= y_d;
      data_out    <= data_d;
      busy        <= busy_d;
    end
  end

  // Next-state, FIFO bookkeeping and output selection.
  always_comb begin
    state_d    = state;
    wk_index_d = wk_index;
    wk_vals_d  = wk_vals;
    rem_mask_d = rem_mask;
    cur_id_d   = cur_id;
    rem_next   = rem_mask;
    program_d  = 1'b0;
    x_d        = px_x_in;
    y_d        = px_y_in;
    data_d     = px_data_in;

    wr_ptr_d = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_d = pop_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_d  = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    err_d    = hs_c & ~idx_ok_c;

    case (state)
      IDLE: begin
        if (pop_c) begin
          wk_index_d = head_c[DW-1:0];
          wk_vals_d  = head_c[DW +: VALS_W];
          rem_mask_d = head_c[ENTRY_W-1 -: NREG];
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (rem_mask == '0) begin
          state_d = IDLE;
        end else begin
          cur_id_d = first_id(rem_mask);
          state_d  = EMIT;
        end
      end
      EMIT: begin
        // Without a slot the pixel passes through and cur_id is held.
        if (slot_c) begin
          program_d  = 1'b1;
          x_d        = wk_index;
          y_d        = DW'(cur_id);
          data_d     = sel_val(wk_vals, cur_id);
          rem_next   = rem_mask & ~(NREG'(1) << cur_id);
          rem_mask_d = rem_next;
          if (rem_next == '0) begin
            state_d = IDLE;
          end else begin
            cur_id_d = first_id(rem_next);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = count_d != CNT_W'(FIFO_DEPTH);
    busy_d  = (count_d != '0) || (state_d != IDLE);
  end

endmodule

// File: tb/tb_rect_program_sequencer.sv
// Self-checking bench for rect_program_sequencer: expected programming words
// are queued when a command is offered and popped as the DUT emits them.
module tb_rect_program_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] px_x_in, px_y_in, px_data_in;
  logic        px_active, vblank;
  logic        program_out;
  logic [11:0] x_out, y_out, data_out;
  logic        busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  rect_program_sequencer_if cif ();

  rect_program_sequencer #(
    .NUM_SHAPES (16),
    .FIFO_DEPTH (4),
    .VBLANK_ONLY(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif.slave),
    .px_x_in    (px_x_in),
    .px_y_in    (px_y_in),
    .px_data_in (px_data_in),
    .px_active  (px_active),
    .vblank     (vblank),
    .program_out(program_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .data_out   (data_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] data;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic drive_cmd(input logic [11:0] idx, input logic [11:0] vx, input logic [11:0] vy,
                           input logic [11:0] vw, input logic [11:0] vh, input logic [11:0] vc,
                           input logic [4:0] m);
    cif.cmd_valid = 1'b1;
    cif.cmd_index = idx;
    cif.cmd_x     = vx;
    cif.cmd_y     = vy;
    cif.cmd_w     = vw;
    cif.cmd_h     = vh;
    cif.cmd_color = vc;
    cif.cmd_mask  = m;
  endtask

  // Reference model: one word per set mask bit, ascending reg ID.
  task automatic expect_words(input logic [11:0] idx, input logic [11:0] vx, input logic [11:0] vy,
                              input logic [11:0] vw, input logic [11:0] vh, input logic [11:0] vc,
                              input logic [4:0] m);
    logic [11:0] v[5];
    word_t       w;
    v[0] = vx; v[1] = vy; v[2] = vw; v[3] = vh; v[4] = vc;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        w.x = idx; w.y = 12'(i); w.data = v[i];
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cif.cmd_ready, program_out, x_out, y_out, data_out, busy, fifo_count, cif.cmd_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b prog=%b x=%0d y=%0d d=%0d busy=%b cnt=%0d err=%b, required all 0",
               cif.cmd_ready, program_out, x_out, y_out, data_out, busy, fifo_count, cif.cmd_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cif.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b, required 1", cif.cmd_ready);
    end
  endtask

  task automatic test_pass_through();
    logic [11:0] ex, ey, ed;
    @(negedge clk);
    px_active = 1'b1; vblank = 1'b0;
    px_x_in = 12'd100; px_y_in = 12'd50; px_data_in = 12'h0F0;
    for (int i = 0; i < 5; i++) begin
      ex = px_x_in; ey = px_y_in; ed = px_data_in;
      @(negedge clk);
      n_checks++;
      if ({program_out, x_out, y_out, data_out} !== {1'b0, ex, ey, ed}) begin
        n_fail++;
        $display("FAIL pass_through[%0d]: got p=%b x=%0d y=%0d d=%h, required p=0 x=%0d y=%0d d=%h",
                 i, program_out, x_out, y_out, data_out, ex, ey, ed);
      end
      px_x_in = 12'($urandom); px_y_in = 12'($urandom); px_data_in = 12'($urandom);
    end
  endtask

  task automatic test_full_program();
    word_t w;
    int    cyc = 0, first = -1, last = -1;
    @(negedge clk);
    vblank = 1'b1; px_active = 1'b0;
    drive_cmd(12'd3, 12'd10, 12'd20, 12'd30, 12'd40, 12'hF00, 5'h1F);
    expect_words(12'd3, 12'd10, 12'd20, 12'd30, 12'd40, 12'hF00, 5'h1F);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      cyc++;
      if (program_out === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        w = exp_q.pop_front();
        n_checks++;
        if ({x_out, y_out, data_out} !== w) begin
          n_fail++;
          $display("FAIL full_word: got x=%0d y=%0d d=%h, required x=%0d y=%0d d=%h",
                   x_out, y_out, data_out, w.x, w.y, w.data);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || last - first != 4) begin
      n_fail++;
      $display("FAIL full_consecutive: left=%0d span=%0d, required left=0 span=4", exp_q.size(), last - first);
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if ({busy, program_out, fifo_count} !== 5'b0) begin
      n_fail++;
      $display("FAIL full_done: busy=%b prog=%b cnt=%0d, required 0 0 0", busy, program_out, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    word_t w;
    int    cyc = 0;
    int    t[4];
    int    n = 0;
    @(negedge clk);
    vblank = 1'b1; px_active = 1'b0;
    drive_cmd(12'd1, 12'h011, 12'h012, 12'h0, 12'h0, 12'h0, 5'h03);
    expect_words(12'd1, 12'h011, 12'h012, 12'h0, 12'h0, 12'h0, 5'h03);
    @(negedge clk);
    drive_cmd(12'd2, 12'h021, 12'h022, 12'h0, 12'h0, 12'h0, 5'h03);
    expect_words(12'd2, 12'h021, 12'h022, 12'h0, 12'h0, 12'h0, 5'h03);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      cyc++;
      if (program_out === 1'b1) begin
        if (n < 4) t[n] = cyc;
        n++;
        w = exp_q.pop_front();
        n_checks++;
        if ({x_out, y_out, data_out} !== w) begin
          n_fail++;
          $display("FAIL b2b_word: got x=%0d y=%0d d=%h, required x=%0d y=%0d d=%h",
                   x_out, y_out, data_out, w.x, w.y, w.data);
        end
      end
    end
    n_checks++;
    if (n != 4 || t[2] - t[1] != 3) begin
      n_fail++;
      $display("FAIL b2b_gap: words=%0d gap=%0d, required words=4 gap=3", n, t[2] - t[1]);
      exp_q.delete();
    end
  endtask

  task automatic test_sparse_pause();
    word_t w;
    int    extra = 0;
    @(negedge clk);
    vblank = 1'b1; px_active = 1'b1;
    drive_cmd(12'd7, 12'h001, 12'h002, 12'h333, 12'h004, 12'h555, 5'h14);
    expect_words(12'd7, 12'h001, 12'h002, 12'h333, 12'h004, 12'h555, 5'h14);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (program_out === 1'b1) extra++;
    end
    px_active = 1'b0;
    @(negedge clk);
    w = exp_q.pop_front();
    n_checks++;
    if ({program_out, x_out, y_out, data_out} !== {1'b1, w}) begin
      n_fail++;
      $display("FAIL sparse_first: got p=%b x=%0d y=%0d d=%h, required p=1 x=%0d y=%0d d=%h",
               program_out, x_out, y_out, data_out, w.x, w.y, w.data);
    end
    px_active = 1'b1; px_x_in = 12'h077; px_y_in = 12'h066; px_data_in = 12'h055;
    @(negedge clk);
    n_checks++;
    if ({program_out, x_out, y_out, data_out} !== {1'b0, 12'h077, 12'h066, 12'h055}) begin
      n_fail++;
      $display("FAIL sparse_pause: got p=%b x=%h y=%h d=%h, required p=0 x=077 y=066 d=055",
               program_out, x_out, y_out, data_out);
    end
    px_active = 1'b0;
    @(negedge clk);
    w = exp_q.pop_front();
    n_checks++;
    if ({program_out, x_out, y_out, data_out} !== {1'b1, w}) begin
      n_fail++;
      $display("FAIL sparse_second: got p=%b x=%0d y=%0d d=%h, required p=1 x=%0d y=%0d d=%h",
               program_out, x_out, y_out, data_out, w.x, w.y, w.data);
    end
    repeat (4) begin
      @(negedge clk);
      if (program_out === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sparse_extra: extra_words=%0d busy=%b, required 0 0", extra, busy);
    end
  endtask

  task automatic test_mask_zero();
    int words = 0;
    @(negedge clk);
    vblank = 1'b1; px_active = 1'b0;
    drive_cmd(12'd5, 12'h1, 12'h2, 12'h3, 12'h4, 12'h5, 5'h00);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL mask0_stored: cnt=%0d, required 1", fifo_count);
    end
    repeat (6) begin
      @(negedge clk);
      if (program_out === 1'b1) words++;
    end
    n_checks++;
    if (words != 0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL mask0_retire: words=%0d busy=%b cnt=%0d, required 0 0 0", words, busy, fifo_count);
    end
  endtask

  task automatic test_vblank_gate();
    word_t w;
    int    words = 0;
    @(negedge clk);
    vblank = 1'b0; px_active = 1'b0;
    drive_cmd(12'd9, 12'h0, 12'h0, 12'h0, 12'h0AB, 12'h0, 5'h08);
    expect_words(12'd9, 12'h0, 12'h0, 12'h0, 12'h0AB, 12'h0, 5'h08);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (program_out === 1'b1) words++;
    end
    n_checks++;
    if (words != 0) begin
      n_fail++;
      $display("FAIL vblank_hold: words=%0d, required 0", words);
    end
    vblank = 1'b1;
    @(negedge clk);
    w = exp_q.pop_front();
    n_checks++;
    if ({program_out, x_out, y_out, data_out} !== {1'b1, w}) begin
      n_fail++;
      $display("FAIL vblank_first: got p=%b x=%0d y=%0d d=%h, required p=1 x=%0d y=%0d d=%h",
               program_out, x_out, y_out, data_out, w.x, w.y, w.data);
    end
  endtask

  task automatic test_fifo_full_reject();
    word_t w;
    int    extra = 0;
    @(negedge clk);
    vblank = 1'b0; px_active = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      n_checks++;
      if (cif.cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_ready[%0d]: got %b, required 1", k, cif.cmd_ready);
      end
      drive_cmd(12'(k + 1), 12'h0, 12'h0, 12'h0, 12'h0, 12'(12'h100 + k), 5'h10);
      expect_words(12'(k + 1), 12'h0, 12'h0, 12'h0, 12'h0, 12'(12'h100 + k), 5'h10);
    end
    @(negedge clk);
    drive_cmd(12'd10, 12'h0, 12'h0, 12'h0, 12'h0, 12'hBAD, 5'h10);
    n_checks++;
    if (fifo_count !== 3'd4 || cif.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full: cnt=%0d ready=%b, required cnt=4 ready=0", fifo_count, cif.cmd_ready);
    end
    repeat (3) @(negedge clk);
    cif.cmd_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_no_push: cnt=%0d, required 4", fifo_count);
    end
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    w = exp_q.pop_front();
    n_checks++;
    if ({program_out, x_out, y_out, data_out} !== {1'b1, w}) begin
      n_fail++;
      $display("FAIL full_one_slot: got p=%b x=%0d y=%0d d=%h, required p=1 x=%0d y=%0d d=%h",
               program_out, x_out, y_out, data_out, w.x, w.y, w.data);
    end
    @(negedge clk);
    n_checks++;
    if (cif.cmd_ready !== 1'b1 || fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL space_freed: ready=%b cnt=%0d, required 1 3", cif.cmd_ready, fifo_count);
    end
    drive_cmd(12'd16, 12'h0, 12'h0, 12'h0, 12'h0, 12'hBAD, 5'h1F);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    n_checks++;
    if (cif.cmd_err !== 1'b1 || fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL reject_pulse: err=%b cnt=%0d, required 1 3", cif.cmd_err, fifo_count);
    end
    @(negedge clk);
    n_checks++;
    if (cif.cmd_err !== 1'b0 || fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL reject_end: err=%b cnt=%0d, required 0 3", cif.cmd_err, fifo_count);
    end
    vblank = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (program_out === 1'b1) begin
        w = exp_q.pop_front();
        n_checks++;
        if ({x_out, y_out, data_out} !== w) begin
          n_fail++;
          $display("FAIL drain_word: got x=%0d y=%0d d=%h, required x=%0d y=%0d d=%h",
                   x_out, y_out, data_out, w.x, w.y, w.data);
        end
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (program_out === 1'b1) extra++;
    end
    n_checks++;
    if (exp_q.size() != 0 || extra != 0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_done: left=%0d extra=%0d busy=%b cnt=%0d, required 0 0 0 0",
               exp_q.size(), extra, busy, fifo_count);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_emit();
    int words = 0;
    @(negedge clk);
    vblank = 1'b1; px_active = 1'b0;
    drive_cmd(12'd5, 12'h1, 12'h2, 12'h3, 12'h4, 12'h5, 5'h1F);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && words < 2; c++) begin
      @(negedge clk);
      if (program_out === 1'b1) words++;
    end
    n_checks++;
    if (words != 2 || y_out !== 12'd1) begin
      n_fail++;
      $display("FAIL pre_reset: words=%0d y=%0d, required 2 1", words, y_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({program_out, x_out, busy, fifo_count, cif.cmd_ready} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: prog=%b x=%0d busy=%b cnt=%0d ready=%b, required all 0",
               program_out, x_out, busy, fifo_count, cif.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    px_active = 1'b1; px_x_in = 12'h123; px_y_in = 12'h045; px_data_in = 12'h678;
    @(negedge clk);
    n_checks++;
    if ({program_out, busy, fifo_count, cif.cmd_ready, x_out, y_out, data_out} !==
        {1'b0, 1'b0, 3'd0, 1'b1, 12'h123, 12'h045, 12'h678}) begin
      n_fail++;
      $display("FAIL post_reset: p=%b busy=%b cnt=%0d ready=%b x=%h y=%h d=%h, required 0 0 0 1 123 045 678",
               program_out, busy, fifo_count, cif.cmd_ready, x_out, y_out, data_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_index = '0; cif.cmd_x = '0; cif.cmd_y = '0;
    cif.cmd_w = '0; cif.cmd_h = '0; cif.cmd_color = '0; cif.cmd_mask = '0;
    px_x_in = '0; px_y_in = '0; px_data_in = '0; px_active = 1'b1; vblank = 1'b0;
    test_reset();
    test_pass_through();
    test_full_program();
    test_back_to_back();
    test_sparse_pause();
    test_mask_zero();
    test_vblank_gate();
    test_fifo_full_reject();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
